// File: rtl/zxuno_regs_pkg.sv
// rtl/zxuno_regs_pkg.sv - shared ZX-UNO register-port constants and strobe bundle
package zxuno_regs_pkg;

    // Default Z80 I/O addresses of the register-file port pair
    localparam logic [15:0] ZXUNO_ADDR_PORT = 16'hFC3B;
    localparam logic [15:0] ZXUNO_DATA_PORT = 16'hFD3B;

    // Well-known register numbers decoded by downstream peripherals
    localparam logic [7:0] REG_COREADDR = 8'hFC;
    localparam logic [7:0] REG_COREBOOT = 8'hFD;

    // The four active-low Z80 control strobes, kept together through the synchroniser
    typedef struct packed {
        logic iorq_n;
        logic rd_n;
        logic wr_n;
        logic m1_n;
    } z80_strobes_t;

    // Strobe set with every line inactive (all high)
    localparam z80_strobes_t STROBES_IDLE = '{iorq_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, m1_n: 1'b1};

    // A decodable I/O access: IORQ low, not an interrupt acknowledge, exactly one of RD/WR low
    function automatic logic is_io_access(input z80_strobes_t s);
        return !s.iorq_n && s.m1_n && (s.rd_n ^ s.wr_n);
    endfunction

endpackage

// File: rtl/zxuno_bus_sync.sv
// rtl/zxuno_bus_sync.sv - multi-stage synchroniser for the asynchronous Z80 strobes
module zxuno_bus_sync
    import zxuno_regs_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  z80_strobes_t strobes_i,
    output z80_strobes_t strobes_o
);

    // Index 0 takes the raw pins, index STAGES-1 is the settled copy
    z80_strobes_t [STAGES-1:0] sync_q;

    // Shift the strobes through the chain; reset presets every stage to inactive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{STROBES_IDLE}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], strobes_i};
        end
    end

    assign strobes_o = sync_q[STAGES-1];

endmodule

// File: rtl/zxuno_regport.sv
// rtl/zxuno_regport.sv - Z80 front-end decoding the ZX-UNO register address/data ports
module zxuno_regport
    import zxuno_regs_pkg::*;
#(
    parameter logic [15:0] ADDR_PORT     = ZXUNO_ADDR_PORT,
    parameter logic [15:0] DATA_PORT     = ZXUNO_DATA_PORT,
    parameter logic [7:0]  RESET_REGADDR = 8'h00,
    parameter int          SYNC_STAGES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    input  logic        cpu_iorq_n,
    input  logic        cpu_rd_n,
    input  logic        cpu_wr_n,
    input  logic        cpu_m1_n,
    output logic [7:0]  zxuno_addr,
    output logic        regaddr_changed,
    output logic        zxuno_regrd,
    output logic        zxuno_regwr,
    output logic [7:0]  zxuno_dout,
    output logic [7:0]  dout,
    output logic        oe
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DATA_WR  = 2'd1;
    localparam logic [1:0] ST_DATA_RD  = 2'd2;
    localparam logic [1:0] ST_WAIT_END = 2'd3;

    localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);

    z80_strobes_t strobes_raw;
    z80_strobes_t strobes_s;
    logic         acc;

    logic [1:0]          state_q, state_d;
    logic [7:0]          addr_q, addr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                changed_q, changed_d;
    logic                regwr_q, regwr_d;
    logic                regrd_q, regrd_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic                settle_done;

    assign strobes_raw = '{iorq_n: cpu_iorq_n, rd_n: cpu_rd_n, wr_n: cpu_wr_n, m1_n: cpu_m1_n};

    zxuno_bus_sync #(
        .STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .clk       (clk),
        .rst       (rst),
        .strobes_i (strobes_raw),
        .strobes_o (strobes_s)
    );

    assign acc = is_io_access(strobes_s);

    // The synchroniser is preset inactive, so right after reset it reports IORQ high even if
    // the CPU is mid-cycle. Count until the chain holds real pin samples before trusting it.
    assign settle_done = (settle_q == SETTLE_W'(SYNC_STAGES));

    // Settle counter next state: runs once after reset, then parks
    always_comb begin
        settle_d = settle_q;
        if (!settle_done) begin
            settle_d = settle_q + 1'b1;
        end
    end

    // Access decoder FSM: one register event per I/O cycle, outputs registered
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        changed_d = 1'b0;
        regwr_d   = regwr_q;
        regrd_d   = regrd_q;
        case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    if (!strobes_s.wr_n && cpu_addr == ADDR_PORT) begin
                        addr_d    = cpu_din;
                        changed_d = 1'b1;
                        state_d   = ST_WAIT_END;
                    end else if (!strobes_s.wr_n && cpu_addr == DATA_PORT) begin
                        wdata_d = cpu_din;
                        regwr_d = 1'b1;
                        state_d = ST_DATA_WR;
                    end else if (!strobes_s.rd_n && cpu_addr == DATA_PORT) begin
                        regrd_d = 1'b1;
                        state_d = ST_DATA_RD;
                    end else begin
                        state_d = ST_WAIT_END;
                    end
                end
            end
            ST_DATA_WR: begin
                if (strobes_s.iorq_n || strobes_s.wr_n) begin
                    regwr_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_DATA_RD: begin
                if (strobes_s.iorq_n || strobes_s.rd_n) begin
                    regrd_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_END: begin
                if (settle_done && strobes_s.iorq_n) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_WAIT_END;
            end
        endcase
    end

    // State and output registers; reset parks in WAIT_END so an in-flight cycle is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_WAIT_END;
            addr_q    <= RESET_REGADDR;
            wdata_q   <= 8'h00;
            changed_q <= 1'b0;
            regwr_q   <= 1'b0;
            regrd_q   <= 1'b0;
            settle_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            changed_q <= changed_d;
            regwr_q   <= regwr_d;
            regrd_q   <= regrd_d;
            settle_q  <= settle_d;
        end
    end

    assign zxuno_addr      = addr_q;
    assign regaddr_changed = changed_q;
    assign zxuno_regwr     = regwr_q;
    assign zxuno_regrd     = regrd_q;
    assign zxuno_dout      = wdata_q;

    // Register-number read-back straight from the raw pins so the CPU sees it within its read
    always_comb begin
        oe   = 1'b0;
        dout = 8'hFF;
        if (!cpu_iorq_n && !cpu_rd_n && cpu_m1_n && cpu_addr == ADDR_PORT) begin
            oe   = 1'b1;
            dout = addr_q;
        end
    end

endmodule
